fifo_writer_helper: RTL and testbench

// - Byte-to-word packer; TX-side counterpart of the FIFO reader serializer.
// - Accepts a byte stream of programmed length and packs 4 bytes per 32-bit word.
// - Writes each word into a downstream 32-bit FIFO.
// - Pads the final partial word with zeros; pulses done when the whole buffer is written.

---
 rtl/fifo_writer_helper.sv | 159 +++++++++++++++
 tb/tb_fifo_writer_helper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_writer_helper.sv
// rtl/fifo_writer_helper.sv - byte-to-word packer feeding a downstream 32-bit FIFO
//
// Accepts a byte stream of a programmed length, packs four bytes per word and
// writes each word to a downstream FIFO. A final partial word is zero padded.
// A one-cycle done pulse follows the write of the last word.
//
// Build option: define FIFO_WRITER_LITTLE_ENDIAN_EN to place lane 0 in [7:0]
// (default: lane 0 in [31:24], matching the RX serializer).
//
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   Write_Request         start pulse, sampled in IDLE only
//   i_TX_BUFFER_LENGTH    byte count, latched on an accepted request
//   serial_input[_valid]  byte stream in; serial_input_ready out
//   i_FIFO_full           downstream FIFO full
//   o_FIFO_din/_wr_en     packed word (registered) and write strobe
//   Pack_Counter          byte lane of the next accepted byte
//   Bytes_Counter         bytes accepted in the current buffer
//   FIFO_Writer_Busy      high in every state except IDLE
//   FIFO_Writer_Done      one-cycle pulse after the last word is written

module fifo_writer_helper #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Write_Request,
    input  logic [LEN_W-1:0]  i_TX_BUFFER_LENGTH,
    input  logic [7:0]        serial_input,
    input  logic              serial_input_valid,
    output logic              serial_input_ready,
    input  logic              i_FIFO_full,
    output logic [DATA_W-1:0] o_FIFO_din,
    output logic              o_FIFO_wr_en,
    output logic [1:0]        Pack_Counter,
    output logic [LEN_W-1:0]  Bytes_Counter,
    output logic              FIFO_Writer_Busy,
    output logic              FIFO_Writer_Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_bytes;
    logic [1:0]          r_pack;
    logic [DATA_W-1:0]   r_word;

    logic                w_xfer;
    logic                w_write;
    logic                w_last_byte;
    logic                w_buf_end;
    logic [LEN_W:0]      w_bytes_inc;
    logic [4:0]          w_lane_lsb;

    assign w_xfer      = serial_input_valid & serial_input_ready;
    assign w_write     = o_FIFO_wr_en;
    // One extra bit so the +1 compare cannot wrap at the counter's maximum.
    assign w_bytes_inc = {1'b0, r_bytes} + {{LEN_W{1'b0}}, 1'b1};
    assign w_last_byte = (w_bytes_inc == {1'b0, r_len});
    assign w_buf_end   = (r_bytes == r_len);

    // Bit position of the lane selected by the pack counter.
`ifdef FIFO_WRITER_LITTLE_ENDIAN_EN
    assign w_lane_lsb = {r_pack, 3'b000};
`else
    assign w_lane_lsb = {~r_pack, 3'b000};
`endif

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (Write_Request) begin
                    w_next_state = (i_TX_BUFFER_LENGTH == '0) ? S_DONE : S_PACK;
                end
            end
            S_PACK: begin
                if (w_xfer && ((r_pack == 2'd3) || w_last_byte)) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!i_FIFO_full) begin
                    w_next_state = w_buf_end ? S_DONE : S_PACK;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        serial_input_ready = 1'b0;
        o_FIFO_wr_en       = 1'b0;
        FIFO_Writer_Busy   = 1'b1;
        FIFO_Writer_Done   = 1'b0;
        case (r_state)
            S_IDLE:  FIFO_Writer_Busy   = 1'b0;
            S_PACK:  serial_input_ready = 1'b1;
            S_WRITE: o_FIFO_wr_en       = ~i_FIFO_full;
            S_DONE:  FIFO_Writer_Done   = 1'b1;
            default: FIFO_Writer_Busy   = 1'b0;
        endcase
    end

    // Datapath: length latch, counters and word assembly. Lanes start cleared,
    // so any lane not filled by an input byte is left as zero padding.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_len   <= '0;
            r_bytes <= '0;
            r_pack  <= '0;
            r_word  <= '0;
        end else begin
            if (r_state == S_IDLE && Write_Request) begin
                r_len   <= i_TX_BUFFER_LENGTH;
                r_bytes <= '0;
                r_pack  <= '0;
                r_word  <= '0;
            end else if (w_xfer) begin
                r_word[w_lane_lsb +: 8] <= serial_input;
                r_pack  <= r_pack + 2'd1;
                r_bytes <= w_bytes_inc[LEN_W-1:0];
            end else if (w_write && !w_buf_end) begin
                r_word  <= '0;
                r_pack  <= '0;
            end
        end
    end

    assign o_FIFO_din    = r_word;
    assign Pack_Counter  = r_pack;
    assign Bytes_Counter = r_bytes;

endmodule

// File: tb/tb_fifo_writer_helper.sv
// tb/tb_fifo_writer_helper.sv - self-checking bench for fifo_writer_helper
module tb_fifo_writer_helper;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Write_Request;
    logic [15:0] i_TX_BUFFER_LENGTH;
    logic [7:0]  serial_input;
    logic        serial_input_valid;
    logic        serial_input_ready;
    logic        i_FIFO_full;
    logic [31:0] o_FIFO_din;
    logic        o_FIFO_wr_en;
    logic [1:0]  Pack_Counter;
    logic [15:0] Bytes_Counter;
    logic        FIFO_Writer_Busy;
    logic        FIFO_Writer_Done;

    fifo_writer_helper dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Write_Request      (Write_Request),
        .i_TX_BUFFER_LENGTH (i_TX_BUFFER_LENGTH),
        .serial_input       (serial_input),
        .serial_input_valid (serial_input_valid),
        .serial_input_ready (serial_input_ready),
        .i_FIFO_full        (i_FIFO_full),
        .o_FIFO_din         (o_FIFO_din),
        .o_FIFO_wr_en       (o_FIFO_wr_en),
        .Pack_Counter       (Pack_Counter),
        .Bytes_Counter      (Bytes_Counter),
        .FIFO_Writer_Busy   (FIFO_Writer_Busy),
        .FIFO_Writer_Done   (FIFO_Writer_Done)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  stim[$];
    logic [31:0] exp_w[$];
    logic [31:0] got_w[$];

    int r_idx;
    int r_nwr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int lane_shift(input int lane);
`ifdef FIFO_WRITER_LITTLE_ENDIAN_EN
        return lane * 8;
`else
        return (3 - lane) * 8;
`endif
    endfunction

    // Reference packing: byte k lands in word k/4 at lane k%4; untouched lanes stay 0.
    task automatic build_expected();
        exp_w.delete();
        for (int k = 0; k < stim.size(); k++) begin
            if (k % 4 == 0) exp_w.push_back(32'h0);
            exp_w[k/4] = exp_w[k/4] | (32'(stim[k]) << lane_shift(k % 4));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(FIFO_Writer_Busy),   32'h0);
        check({tag, "_done"},  32'(FIFO_Writer_Done),   32'h0);
        check({tag, "_ready"}, 32'(serial_input_ready), 32'h0);
        check({tag, "_wr_en"}, 32'(o_FIFO_wr_en),       32'h0);
        check({tag, "_din"},   o_FIFO_din,              32'h0);
        check({tag, "_pack"},  32'(Pack_Counter),       32'h0);
        check({tag, "_bytes"}, 32'(Bytes_Counter),      32'h0);
    endtask

    // Runs one buffer from the global stim queue. full_until forces full for the
    // first cycles of the run; exp_done (if >= 0) is the expected Done cycle
    // counted from the request cycle.
    task automatic run_buffer(input int gap_pct, input int full_pct,
                              input int full_until, input int exp_done);
        int len      = stim.size();
        int idx      = 0;
        int done_cyc = -1;
        int last_wr  = -1;
        build_expected();
        got_w.delete();
        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            @(posedge CLK); #1;
            Write_Request      = (cyc == 0) || ($urandom_range(3) == 0);
            i_TX_BUFFER_LENGTH = (cyc == 0) ? 16'(len) : 16'($urandom);
            serial_input_valid = (idx < len) && ($urandom_range(99) >= gap_pct);
            serial_input       = (idx < len) ? stim[idx] : 8'($urandom);
            i_FIFO_full        = (cyc < full_until) || ($urandom_range(99) < full_pct);
            @(negedge CLK);
            if (cyc > 0) begin
                check("busy",     32'(FIFO_Writer_Busy), 32'h1);
                check("bytes_cnt", 32'(Bytes_Counter),   32'(idx));
                check("pack_cnt",  32'(Pack_Counter),    32'(idx % 4));
            end
            if (cyc > len && cyc < full_until) begin
                check("full_wr_en", 32'(o_FIFO_wr_en),       32'h0);
                check("full_ready", 32'(serial_input_ready), 32'h0);
                check("full_din",   o_FIFO_din,              exp_w[0]);
            end
            if (o_FIFO_wr_en) begin
                check("wr_while_full", 32'(i_FIFO_full), 32'h0);
                got_w.push_back(o_FIFO_din);
                last_wr = cyc;
            end
            if (serial_input_valid && serial_input_ready) idx++;
            if (FIFO_Writer_Done) done_cyc = cyc;
        end
        check("done_seen", 32'(done_cyc >= 0), 32'h1);
        check("n_writes", 32'(got_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
            check("word", got_w[i], exp_w[i]);
        if (len > 0) check("done_latency", 32'(done_cyc), 32'(last_wr + 1));
        if (exp_done >= 0) check("done_cycle", 32'(done_cyc), 32'(exp_done));
        @(posedge CLK); #1;
        Write_Request      = 1'b0;
        serial_input_valid = 1'b0;
        i_FIFO_full        = 1'b0;
        @(negedge CLK);
        check("done_width", 32'(FIFO_Writer_Done), 32'h0);
        check("idle_busy",  32'(FIFO_Writer_Busy), 32'h0);
    endtask

    initial begin
        RESET              = 1'b1;
        Write_Request      = 1'b0;
        i_TX_BUFFER_LENGTH = 16'h0;
        serial_input       = 8'h0;
        serial_input_valid = 1'b0;
        i_FIFO_full        = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        @(posedge CLK); #1;
        RESET = 1'b0;

        // len=8 back-to-back, no backpressure
        stim.delete();
        for (int k = 1; k <= 8; k++) stim.push_back(8'(k));
        run_buffer(0, 0, 0, 11);

        // len=5, partial final word padded with zeros
        stim.delete();
        stim.push_back(8'h0A); stim.push_back(8'h0B); stim.push_back(8'h0C);
        stim.push_back(8'h0D); stim.push_back(8'hEE);
        run_buffer(0, 0, 0, 8);

        // len=4 with full held for 3 cycles in WRITE
        stim.delete();
        stim.push_back(8'h11); stim.push_back(8'h22);
        stim.push_back(8'h33); stim.push_back(8'h44);
        run_buffer(0, 0, 8, 9);

        // len=0: Done the cycle after the request, no writes
        stim.delete();
        run_buffer(0, 0, 0, 1);

        // Reset part-way through a len=8 buffer after 6 bytes
        stim.delete();
        for (int k = 0; k < 8; k++) stim.push_back(8'($urandom));
        r_idx = 0;
        r_nwr = 0;
        for (int cyc = 0; cyc < 60 && r_idx < 6; cyc++) begin
            @(posedge CLK); #1;
            Write_Request      = (cyc == 0);
            i_TX_BUFFER_LENGTH = 16'd8;
            serial_input_valid = 1'b1;
            serial_input       = stim[r_idx];
            i_FIFO_full        = 1'b0;
            @(negedge CLK);
            if (o_FIFO_wr_en) r_nwr++;
            if (serial_input_valid && serial_input_ready) r_idx++;
        end
        check("rst_pre_bytes",  32'(r_idx), 32'd6);
        check("rst_pre_writes", 32'(r_nwr), 32'd1);
        @(posedge CLK); #1;
        Write_Request      = 1'b0;
        serial_input_valid = 1'b0;
        #1 RESET = 1'b1;
        #1 check_all_zero("rst_async");
        repeat (2) begin
            @(negedge CLK);
            check("rst_hold_wr_en", 32'(o_FIFO_wr_en), 32'h0);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        stim.delete();
        for (int k = 0; k < 7; k++) stim.push_back(8'($urandom));
        run_buffer(0, 0, 0, 7 + 2 + 1);

        // Randomized buffers with random gaps and backpressure
        for (int t = 0; t < 30; t++) begin
            int n;
            int g;
            int f;
            n = int'($urandom_range(13, 0));
            g = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(50));
            f = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(50));
            stim.delete();
            for (int k = 0; k < n; k++) stim.push_back(8'($urandom));
            run_buffer(g, f, 0, (g == 0 && f == 0) ? (n + (n + 3) / 4 + 1) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
